// File: rtl/mix_resp_misr_pkg.sv
// Shared types and the MISR step function for the mix response compactor.
package mix_resp_pkg;

    // Run-control states of the compactor.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int          RESP_W   = 16;
    localparam logic [15:0] DEF_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1
    localparam logic [15:0] DEF_SEED = 16'h0000;

    // One MISR step: shift left, feed the tap parity into bit 0, then fold in the response.
    function automatic logic [RESP_W-1:0] misr_step(
        input logic [RESP_W-1:0] sig,
        input logic [RESP_W-1:0] resp,
        input logic [RESP_W-1:0] taps
    );
        logic fb;
        fb = ^(sig & taps);
        return {sig[RESP_W-2:0], fb} ^ resp;
    endfunction

endpackage

// File: rtl/mix_resp_misr_core.sv
// MISR signature register: load restores the seed, enable folds one response in.
module misr_core
    import mix_resp_pkg::*;
#(
    parameter int                WIDTH = RESP_W,
    parameter logic [WIDTH-1:0]  TAPS  = DEF_TAPS,
    parameter logic [WIDTH-1:0]  SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] resp_i,
    output logic [WIDTH-1:0] sig_o,
    output logic [WIDTH-1:0] sig_next_o
);

    logic [WIDTH-1:0] sig_q;
    logic [WIDTH-1:0] sig_d;

    // Next signature: load wins over enable so a restart never folds a sample in.
    always_comb begin
        sig_next_o = misr_step(sig_q, resp_i, TAPS);
        sig_d      = sig_q;
        if (load_i) begin
            sig_d = SEED;
        end else if (en_i) begin
            sig_d = sig_next_o;
        end
    end

    // Signature register, seeded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= SEED;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_o = sig_q;

endmodule

// File: rtl/mix_resp_misr.sv
// Response compactor: folds LEN valid samples after start into a MISR and checks the result.
//
// Handshake: resp is consumed on every clock where resp_valid is high while busy is high
// and start is low; there is no backpressure. start always wins over resp_valid.
module mix_resp_misr
    import mix_resp_pkg::*;
#(
    parameter int                WIDTH = RESP_W,
    parameter int                LEN   = 32,
    parameter logic [WIDTH-1:0]  TAPS  = DEF_TAPS,
    parameter logic [WIDTH-1:0]  SEED  = DEF_SEED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp,
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             sig_valid,
    output logic [WIDTH-1:0] signature,
    output logic             pass
);

    localparam int CNT_W = $clog2(LEN + 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pass_q, pass_d;
    logic             core_load;
    logic             core_en;
    logic [WIDTH-1:0] sig_next;

    misr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .load_i     (core_load),
        .en_i       (core_en),
        .resp_i     (resp),
        .sig_o      (signature),
        .sig_next_o (sig_next)
    );

    // Next-state, sample counting and golden compare on the final step.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pass_d    = pass_q;
        core_load = 1'b0;
        core_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    count_d   = '0;
                    core_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (start) begin
                    count_d   = '0;
                    core_load = 1'b1;
                end else if (resp_valid) begin
                    core_en = 1'b1;
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(LEN - 1)) begin
                        state_d = ST_DONE;
                        pass_d  = (sig_next == golden);
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    count_d   = '0;
                    pass_d    = 1'b0;
                    core_load = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign sig_valid = (state_q == ST_DONE);
    assign pass      = pass_q;

endmodule

// File: tb/tb_mix_resp_misr.sv
// Directed bench for mix_resp_misr over four parameterisations sharing one stimulus bus.
module tb_mix_resp_misr;

    localparam logic [15:0] TAPS   = 16'hB400;
    localparam logic [15:0] SEED_C = 16'h8000;
    localparam logic [15:0] SEED_D = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        resp_valid = 1'b0;
    logic [15:0] resp = '0;
    logic [15:0] golden = '0;

    logic        busy_a, sv_a, pass_a;
    logic        busy_b, sv_b, pass_b;
    logic        busy_c, sv_c, pass_c;
    logic        busy_d, sv_d, pass_d;
    logic [15:0] sig_a, sig_b, sig_c, sig_d;

    int tests = 0;
    int fails = 0;

    logic [15:0] exp_q[$];
    logic        exp_pass_q[$];

    // clock / reset
    always #5 clk = ~clk;

    mix_resp_misr #(.WIDTH(16), .LEN(1), .TAPS(TAPS), .SEED(16'h0000)) u_a (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
        .golden(golden), .busy(busy_a), .sig_valid(sv_a), .signature(sig_a), .pass(pass_a));
    mix_resp_misr #(.WIDTH(16), .LEN(2), .TAPS(TAPS), .SEED(16'h0000)) u_b (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
        .golden(golden), .busy(busy_b), .sig_valid(sv_b), .signature(sig_b), .pass(pass_b));
    mix_resp_misr #(.WIDTH(16), .LEN(1), .TAPS(TAPS), .SEED(SEED_C)) u_c (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
        .golden(golden), .busy(busy_c), .sig_valid(sv_c), .signature(sig_c), .pass(pass_c));
    mix_resp_misr #(.WIDTH(16), .LEN(32), .TAPS(TAPS), .SEED(SEED_D)) u_d (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp(resp),
        .golden(golden), .busy(busy_d), .sig_valid(sv_d), .signature(sig_d), .pass(pass_d));

    // reference MISR step, written bit by bit
    function automatic logic [15:0] model_step(input logic [15:0] s, input logic [15:0] r);
        logic fb;
        fb = 1'b0;
        for (int i = 0; i < 16; i++) fb = fb ^ (s[i] & TAPS[i]);
        return {s[14:0], fb} ^ r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one clock with the given inputs, then return them to idle; outputs settle #1 after the edge
    task automatic drive(input logic st, input logic v, input logic [15:0] r);
        start = st;
        resp_valid = v;
        resp = r;
        @(posedge clk);
        #1;
        start = 1'b0;
        resp_valid = 1'b0;
        resp = '0;
    endtask

    // scoreboard pop: called on the cycle the DUT must present its result
    task automatic check_result(input string tag, input logic sv, input logic [15:0] sig,
                                input logic ps);
        logic [15:0] e_sig;
        logic        e_pass;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e_sig  = exp_q.pop_front();
            e_pass = exp_pass_q.pop_front();
            chk({tag, "_valid"}, 16'(sv), 16'h1);
            chk({tag, "_sig"}, sig, e_sig);
            chk({tag, "_pass"}, 16'(ps), 16'(e_pass));
        end
    endtask

    logic [15:0] m;
    logic [15:0] smp[32];

    initial begin
        // reset
        drive(0, 0, 0);
        drive(0, 0, 0);
        rst = 1'b0;
        chk("rst_sig_a", sig_a, 16'h0000);
        chk("rst_busy_a", 16'(busy_a), 16'h0);
        chk("rst_sv_a", 16'(sv_a), 16'h0);
        chk("rst_pass_a", 16'(pass_a), 16'h0);
        chk("rst_sig_c", sig_c, SEED_C);
        chk("rst_sig_d", sig_d, SEED_D);

        // case 1: LEN=1, single sample 0x0001, and resp_valid ignored in IDLE
        drive(0, 1, 16'h1234);
        chk("idle_ignore_sig_a", sig_a, 16'h0000);
        golden = 16'h0000;
        drive(1, 0, 0);
        chk("c1_busy_a", 16'(busy_a), 16'h1);
        m = model_step(16'h0000, 16'h0001);
        exp_q.push_back(m);
        exp_pass_q.push_back(m == golden);
        drive(0, 1, 16'h0001);
        check_result("c1", sv_a, sig_a, pass_a);
        chk("c1_busy_low_a", 16'(busy_a), 16'h0);

        // case 2: LEN=2, samples 1 then 0 with matching golden
        golden = 16'h0002;
        drive(1, 0, 0);
        drive(0, 1, 16'h0001);
        chk("c2_mid_sv_b", 16'(sv_b), 16'h0);
        chk("c2_mid_busy_b", 16'(busy_b), 16'h1);
        m = model_step(model_step(16'h0000, 16'h0001), 16'h0000);
        exp_q.push_back(m);
        exp_pass_q.push_back(m == golden);
        drive(0, 1, 16'h0000);
        check_result("c2", sv_b, sig_b, pass_b);
        // DONE holds against further samples
        drive(0, 1, 16'hFFFF);
        chk("c2_hold_sig_b", sig_b, 16'h0002);
        chk("c2_hold_sv_b", 16'(sv_b), 16'h1);
        chk("c2_hold_pass_b", 16'(pass_b), 16'h1);

        // case 3: SEED=0x8000, LEN=1, resp=0, golden mismatch
        golden = 16'h0000;
        drive(1, 0, 0);
        chk("c3_pass_cleared_b", 16'(pass_b), 16'h0);
        chk("c3_seed_c", sig_c, SEED_C);
        m = model_step(SEED_C, 16'h0000);
        exp_q.push_back(m);
        exp_pass_q.push_back(m == golden);
        drive(0, 1, 16'h0000);
        check_result("c3", sv_c, sig_c, pass_c);

        // case 4: LEN=2 with gaps between valid samples
        golden = 16'h0002;
        drive(1, 0, 0);
        drive(0, 1, 16'h0001);
        drive(0, 0, 16'hBEEF);
        drive(0, 0, 16'hBEEF);
        chk("c4_gap_busy_b", 16'(busy_b), 16'h1);
        chk("c4_gap_sv_b", 16'(sv_b), 16'h0);
        chk("c4_gap_sig_b", sig_b, model_step(16'h0000, 16'h0001));
        exp_q.push_back(16'h0002);
        exp_pass_q.push_back(1'b1);
        drive(0, 1, 16'h0000);
        check_result("c4", sv_b, sig_b, pass_b);

        // case 5: start during RUN with resp_valid dropped, then a full LEN=32 run
        drive(1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 16'($urandom_range(0, 16'hFFFF)));
        drive(1, 1, 16'h5A5A);
        chk("c5_restart_sig_d", sig_d, SEED_D);
        chk("c5_restart_busy_d", 16'(busy_d), 16'h1);
        m = SEED_D;
        for (int i = 0; i < 32; i++) begin
            smp[i] = 16'($urandom_range(0, 16'hFFFF));
            m = model_step(m, smp[i]);
        end
        golden = ~m;
        exp_q.push_back(m);
        exp_pass_q.push_back(1'b0);
        for (int i = 0; i < 32; i++) begin
            if (i == 31) chk("c5_before_last_sv_d", 16'(sv_d), 16'h0);
            drive(0, 1, smp[i]);
        end
        check_result("c5", sv_d, sig_d, pass_d);

        // case 6: reset after 5 samples, then a clean LEN=32 run with gaps
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 16'($urandom_range(0, 16'hFFFF)));
        rst = 1'b1;
        drive(0, 0, 0);
        rst = 1'b0;
        chk("c6_rst_busy_d", 16'(busy_d), 16'h0);
        chk("c6_rst_sig_d", sig_d, SEED_D);
        chk("c6_rst_sv_d", 16'(sv_d), 16'h0);
        m = SEED_D;
        for (int i = 0; i < 32; i++) begin
            smp[i] = 16'($urandom_range(0, 16'hFFFF));
            m = model_step(m, smp[i]);
        end
        golden = m;
        exp_q.push_back(m);
        exp_pass_q.push_back(1'b1);
        drive(1, 0, 0);
        for (int i = 0; i < 32; i++) begin
            if ($urandom_range(0, 3) == 0) drive(0, 0, 16'hFFFF);
            if (i == 31) chk("c6_before_last_busy_d", 16'(busy_d), 16'h1);
            drive(0, 1, smp[i]);
        end
        check_result("c6", sv_d, sig_d, pass_d);

        chk("sb_drained", 16'(exp_q.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
